// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences the shared datapath
// over several cycles per instruction and stalls on the memory ready handshake.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb = 2'b11;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StExecute: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                pcen       = zero;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Strobes must be quiet during reset even though FETCH decodes mem_ready.
        if (!rst_n) begin
            irwrite    = 1'b0;
            pcen       = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;

endmodule
